conv_host_mem: RTL and testbench
================================

Name: conv_host_mem

Overview:
- Host-side responder for the CONV accelerator. Owns the image memory, the layer-0 memory and the layer-1 memory that CONV addresses.
- Loads a 64x64 image from an input stream, then raises `ready`.
- Serves CONV's `iaddr`/`crd` reads and accepts its `cwr` writes.
- When CONV drops `busy`, streams the 32x32 layer-1 result out on a valid/ready port.

Parameters:
- DATA_W, 20, width of every data word (signed, Q4.16).
- IMG_AW, 12, image and L0 address width (4096 words).
- L1_AW, 10, L1 address width (1024 words).

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- in_valid  in  1  image load word valid
- in_data  in  DATA_W  image load word, raster order from address 0
- in_ready  out  1  load word accepted when in_valid & in_ready
- ready  out  1  start request to CONV
- busy  in  1  CONV busy
- iaddr  in  IMG_AW  image read address from CONV
- idata  out  DATA_W  image read data
- cwr  in  1  layer write strobe
- caddr_wr  in  IMG_AW  layer write address
- cdata_wr  in  DATA_W  layer write data
- crd  in  1  layer read strobe
- caddr_rd  in  IMG_AW  layer read address
- cdata_rd  out  DATA_W  layer read data
- csel  in  3  layer select: 3'b001 = L0, 3'b011 = L1, others = none
- out_valid  out  1  result word valid
- out_data  out  DATA_W  L1 word
- out_last  out  1  high with the final word (L1 address 1023)
- out_ready  in  1  downstream accepts
- done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset values: state IDLE; in_ready=0, ready=0, idata=0, cdata_rd=0, out_valid=0, out_data=0, out_last=0, done=0. Load and dump counters cleared. Memory contents are not cleared.
- Reset asserted mid-operation aborts immediately to IDLE; any partial dump is abandoned.
- States:
  - IDLE: in_ready=0. Go to LOAD when in_valid=1.
  - LOAD: in_ready=1. Each accepted word is written to img[load_cnt] and load_cnt increments. After the word at 4095 is accepted, go to START and clear in_ready the next cycle.
  - START: ready=1. Hold until busy is sampled 1, then clear ready (registered, so it drops one cycle after busy is seen) and go to RUN.
  - RUN: ready=0. Serve the CONV port. Go to DUMP on the first cycle busy is sampled 0.
  - DUMP: present L1 words 0..1023 in order. Advance on out_valid & out_ready. out_valid stays high and out_data stays stable while out_ready=0. out_last=1 only with word 1023. After word 1023 is accepted, go to DONE.
  - DONE: done=1 for one cycle, then IDLE.
- Image read: idata is registered, 1-cycle latency. idata(t+1) = img[iaddr(t)], served in every state. CONV holds iaddr stable for two cycles and samples on the second.
- Layer read: cdata_rd is registered, 1-cycle latency.
  - If crd(t)=1 and csel=001: cdata_rd(t+1) = L0[caddr_rd].
  - If crd(t)=1 and csel=011: cdata_rd(t+1) = L1[caddr_rd[L1_AW-1:0]].
  - crd=1 with any other csel gives 0. crd=0 holds the previous value.
- Layer write, on a clock edge with cwr=1:
  - csel=001: L0[caddr_wr] <= cdata_wr.
  - csel=011: L1[caddr_wr[L1_AW-1:0]] <= cdata_wr. Upper address bits are ignored.
  - Any other csel: write dropped.
- Simultaneous cwr and crd to the same memory and address: the read returns the old data (read-before-write).
- cwr/crd arriving outside RUN are still honoured (memory is always live). DUMP reads L1 through a separate internal read path and has priority over no external access.
- The DUMP read path is pre-fetched: entering DUMP, out_valid rises 1 cycle after the state change. A full dump with out_ready held at 1 takes 1025 cycles plus 1 cycle for DONE.
- busy already 1 on entry to START: ready is still driven for one cycle, then the block moves to RUN.
- busy dropping while ready=1 and before busy was ever seen high: ignored; the block stays in START.

Test Plan:
- Reset mid-LOAD after 100 words: all outputs 0, state IDLE. Reloading 4096 words then gives ready=1.
- Load img[a]=a, then drive iaddr=0x041 for 2 cycles: idata=0x00041 on the cycle after iaddr is applied.
- cwr with csel=001, caddr_wr=0x123, cdata_wr=0xABCDE, then crd with csel=001, caddr_rd=0x123: cdata_rd=0xABCDE one cycle later. The same address with csel=011 returns L1[0x123], not the L0 word.
- Write with csel=011 to address 0xFBF: lands in L1[0x3BF]. Write with csel=010: no memory changes.
- Handshake: ready is held until busy=1, drops on the next cycle. busy high for 50 cycles then low starts DUMP: out_valid rises, first out_data=L1[0].
- DUMP with out_ready toggling 1,0,1,...: every word 0..1023 appears exactly once in order, data stable during stalls, out_last only on word 1023, done pulses once, then the state is IDLE.

Source files
------------

// File: rtl/conv_host_mem_if.sv
// Bundle of every signal between conv_host_mem and its neighbours.
// It carries three groups: the image load stream, the CONV memory port
// and the result stream.
// The slave modport is the memory side. The master modport is the side
// that drives the load stream, acts as CONV and sinks the result stream.
interface conv_host_mem_if #(
   parameter int DATA_W = 20,
   parameter int IMG_AW = 12
);
   // image load stream
   logic              in_valid;
   logic [DATA_W-1:0] in_data;
   logic              in_ready;

   // CONV start handshake
   logic              ready;
   logic              busy;

   // CONV image read port
   logic [IMG_AW-1:0] iaddr;
   logic [DATA_W-1:0] idata;

   // CONV layer write port
   logic              cwr;
   logic [IMG_AW-1:0] caddr_wr;
   logic [DATA_W-1:0] cdata_wr;

   // CONV layer read port
   logic              crd;
   logic [IMG_AW-1:0] caddr_rd;
   logic [DATA_W-1:0] cdata_rd;
   logic [2:0]        csel;

   // result stream
   logic              out_valid;
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_ready;
   logic              done;

   modport slave (
      input  in_valid, in_data, busy, iaddr,
      input  cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
      input  out_ready,
      output in_ready, ready, idata, cdata_rd,
      output out_valid, out_data, out_last, done
   );

   modport master (
      output in_valid, in_data, busy, iaddr,
      output cwr, caddr_wr, cdata_wr, crd, caddr_rd, csel,
      output out_ready,
      input  in_ready, ready, idata, cdata_rd,
      input  out_valid, out_data, out_last, done
   );
endinterface

// File: rtl/conv_host_mem.sv
// Host-side memory responder for the CONV accelerator.
// It owns three memories: the 64x64 image, the layer-0 map and the
// 32x32 layer-1 map.
// Operating sequence:
//   1. Load the image from the input stream.
//   2. Request a CONV run.
//   3. Serve CONV's reads and writes while CONV is busy.
//   4. Stream layer 1 out on a valid/ready port.
// The memories are never cleared. Only the control state and the output
// registers reset.
module conv_host_mem #(
   parameter int DATA_W = 20,
   parameter int IMG_AW = 12,
   parameter int L1_AW  = 10
) (
   input  logic           clk,
   input  logic           reset,
   conv_host_mem_if.slave bus
);

   localparam int IMG_WORDS = 1 << IMG_AW;
   localparam int L1_WORDS  = 1 << L1_AW;

   localparam logic [2:0] SEL_L0 = 3'b001;
   localparam logic [2:0] SEL_L1 = 3'b011;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_RUN,
      S_DUMP,
      S_DONE
   } state_t;

   state_t r_state;
   state_t w_state_next;

   // Memories: the image and L0 share the 12-bit space; L1 is 1024 words.
   logic [DATA_W-1:0] r_img_mem [IMG_WORDS];
   logic [DATA_W-1:0] r_l0_mem  [IMG_WORDS];
   logic [DATA_W-1:0] r_l1_mem  [L1_WORDS];

   logic [IMG_AW-1:0] r_load_cnt;
   logic [L1_AW-1:0]  r_dump_addr;

   logic [DATA_W-1:0] r_idata;
   logic [DATA_W-1:0] r_cdata_rd;
   logic              r_out_valid;
   logic [DATA_W-1:0] r_out_data;
   logic              r_out_last;

   logic w_in_ready;
   logic w_ready;
   logic w_done;
   logic w_load_fire;
   logic w_out_fire;
   logic w_dump_fetch;
   logic w_dump_end;
   logic w_l0_wr;
   logic w_l1_wr;

   // Accepted load word, handshake on the result stream, layer write strobes.
   assign w_load_fire = (r_state == S_LOAD) && bus.in_valid;
   assign w_out_fire  = r_out_valid && bus.out_ready;
   assign w_dump_end  = w_out_fire && r_out_last;
   assign w_l0_wr     = bus.cwr && (bus.csel == SEL_L0);
   assign w_l1_wr     = bus.cwr && (bus.csel == SEL_L1);

   // A dump fetch happens in two cases:
   //   - on the first DUMP cycle (output empty), which pre-fetches word 0;
   //   - when a non-final word is accepted, which refills the output
   //     register the same cycle.
   assign w_dump_fetch = (r_state == S_DUMP) &&
                         (!r_out_valid || (w_out_fire && !r_out_last));

   // State register; reset aborts any operation back to IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state and state-decoded control outputs.
   always_comb begin
      w_state_next = r_state;
      w_in_ready   = 1'b0;
      w_ready      = 1'b0;
      w_done       = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (bus.in_valid) begin
               w_state_next = S_LOAD;
            end
         end
         S_LOAD: begin
            w_in_ready = 1'b1;
            if (w_load_fire && (r_load_cnt == '1)) begin
               w_state_next = S_START;
            end
         end
         S_START: begin
            // Held here until busy is seen high. A low busy is ignored
            // until then, and ready lasts at least one cycle.
            w_ready = 1'b1;
            if (bus.busy) begin
               w_state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (!bus.busy) begin
               w_state_next = S_DUMP;
            end
         end
         S_DUMP: begin
            if (w_dump_end) begin
               w_state_next = S_DONE;
            end
         end
         S_DONE: begin
            w_done       = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign bus.in_ready = w_in_ready;
   assign bus.ready    = w_ready;
   assign bus.done     = w_done;

   // Load counter: raster address of the next image word; restarts in IDLE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_load_cnt <= '0;
      end else if (r_state == S_IDLE) begin
         r_load_cnt <= '0;
      end else if (w_load_fire) begin
         r_load_cnt <= r_load_cnt + 1'b1;
      end
   end

   // Image memory write from the load stream.
   always_ff @(posedge clk) begin
      if (w_load_fire) begin
         r_img_mem[r_load_cnt] <= bus.in_data;
      end
   end

   // Image read: always live, one-cycle registered latency.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_idata <= '0;
      end else begin
         r_idata <= r_img_mem[bus.iaddr];
      end
   end

   // L0 write port. The read below sees the old word on a same-address collision.
   always_ff @(posedge clk) begin
      if (w_l0_wr) begin
         r_l0_mem[bus.caddr_wr] <= bus.cdata_wr;
      end
   end

   // L1 write port; upper address bits beyond the L1 range are ignored.
   always_ff @(posedge clk) begin
      if (w_l1_wr) begin
         r_l1_mem[bus.caddr_wr[L1_AW-1:0]] <= bus.cdata_wr;
      end
   end

   // Layer read: selected memory on crd, zero for an unmapped select, else hold.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_cdata_rd <= '0;
      end else if (bus.crd) begin
         case (bus.csel)
            SEL_L0:  r_cdata_rd <= r_l0_mem[bus.caddr_rd];
            SEL_L1:  r_cdata_rd <= r_l1_mem[bus.caddr_rd[L1_AW-1:0]];
            default: r_cdata_rd <= '0;
         endcase
      end
   end

   // Dump engine: a private L1 read path feeding a one-deep output register.
   // The output register holds its data while the consumer stalls.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_dump_addr <= '0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_last  <= 1'b0;
      end else if (r_state != S_DUMP) begin
         r_dump_addr <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end else if (w_dump_fetch) begin
         r_out_data  <= r_l1_mem[r_dump_addr];
         r_out_valid <= 1'b1;
         r_out_last  <= (r_dump_addr == '1);
         r_dump_addr <= r_dump_addr + 1'b1;
      end else if (w_out_fire) begin
         // Final word taken: nothing left to present.
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
      end
   end

   assign bus.idata     = r_idata;
   assign bus.cdata_rd  = r_cdata_rd;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_last  = r_out_last;

endmodule

// File: tb/tb_conv_host_mem.sv
// Directed bench for conv_host_mem. A queue holds the expected layer read
// data and dump words; entries are pushed when the stimulus is driven and
// popped when the design delivers the result.
module tb_conv_host_mem;

   localparam int DATA_W = 20;
   localparam int IMG_AW = 12;
   localparam int L1_AW  = 10;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   conv_host_mem_if #(.DATA_W(DATA_W), .IMG_AW(IMG_AW)) bus ();

   conv_host_mem #(
      .DATA_W (DATA_W),
      .IMG_AW (IMG_AW),
      .L1_AW  (L1_AW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   int n_cmp = 0;
   int n_err = 0;

   logic [DATA_W-1:0] exp_q[$];
   logic [DATA_W-1:0] l0_model[int];
   logic [DATA_W-1:0] l1_model[1024];

   // Hard stop in case the design never produces an awaited event.
   initial begin
      #(3_000_000);
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, ".in_ready"},  32'(bus.in_ready),  32'h0);
      check({tag, ".ready"},     32'(bus.ready),     32'h0);
      check({tag, ".idata"},     32'(bus.idata),     32'h0);
      check({tag, ".cdata_rd"},  32'(bus.cdata_rd),  32'h0);
      check({tag, ".out_valid"}, 32'(bus.out_valid), 32'h0);
      check({tag, ".out_data"},  32'(bus.out_data),  32'h0);
      check({tag, ".out_last"},  32'(bus.out_last),  32'h0);
      check({tag, ".done"},      32'(bus.done),      32'h0);
   endtask

   // Offer n words base+i; a word counts as taken at an edge where in_ready was high.
   task automatic load_image(input int n, input logic [DATA_W-1:0] base);
      int i;
      int guard;
      logic taken;
      i = 0;
      guard = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = base;
      while (i < n && guard < n + 100) begin
         taken = bus.in_ready;
         tick();
         guard++;
         if (taken) begin
            i++;
            bus.in_data = base + DATA_W'(i);
         end
      end
      bus.in_valid = 1'b0;
      check("load_count", 32'(i), 32'(n));
   endtask

   task automatic layer_write(input logic [2:0] sel, input logic [11:0] addr,
                              input logic [DATA_W-1:0] data);
      bus.cwr = 1'b1;
      bus.csel = sel;
      bus.caddr_wr = addr;
      bus.cdata_wr = data;
      tick();
      bus.cwr = 1'b0;
      if (sel == 3'b001) l0_model[int'(addr)] = data;
      if (sel == 3'b011) l1_model[int'(addr[9:0])] = data;
   endtask

   task automatic layer_read(input string tag, input logic [2:0] sel,
                             input logic [11:0] addr, input logic [DATA_W-1:0] exp);
      bus.crd = 1'b1;
      bus.csel = sel;
      bus.caddr_rd = addr;
      exp_q.push_back(exp);
      tick();
      bus.crd = 1'b0;
      check(tag, 32'(bus.cdata_rd), 32'(exp_q.pop_front()));
   endtask

   function automatic logic [DATA_W-1:0] l1_pat(input int i);
      return DATA_W'(i * 32'h1F3 + 32'h5A5A5);
   endfunction

   initial begin
      int idx;
      int cyc;
      int done_cnt;
      logic rdy;
      logic prev_stall;
      logic [DATA_W-1:0] prev_data;
      logic [DATA_W-1:0] held;

      reset = 1'b1;
      bus.in_valid = 1'b0;  bus.in_data = '0;
      bus.busy = 1'b0;      bus.iaddr = '0;
      bus.cwr = 1'b0;       bus.caddr_wr = '0;  bus.cdata_wr = '0;
      bus.crd = 1'b0;       bus.caddr_rd = '0;  bus.csel = 3'b000;
      bus.out_ready = 1'b0;

      // Reset state
      tick();
      tick();
      check_all_zero("reset");
      reset = 1'b0;
      tick();
      check("idle_in_ready", 32'(bus.in_ready), 32'h0);

      // Partial load, then reset mid-LOAD
      load_image(100, 20'h80000);
      check("mid_load_in_ready", 32'(bus.in_ready), 32'h1);
      reset = 1'b1;
      #1;
      check_all_zero("mid_load_reset");
      tick();
      reset = 1'b0;
      tick();
      check("after_reset_idle", 32'(bus.in_ready), 32'h0);

      // Full load img[a]=a, then ready waits for busy
      load_image(4096, 20'h00000);
      check("load_end_in_ready", 32'(bus.in_ready), 32'h0);
      check("start_ready", 32'(bus.ready), 32'h1);
      repeat (5) tick();
      check("ready_held_no_busy", 32'(bus.ready), 32'h1);
      bus.busy = 1'b1;
      check("ready_with_busy", 32'(bus.ready), 32'h1);
      tick();
      check("ready_drop", 32'(bus.ready), 32'h0);

      // Image reads, one-cycle latency, held for two cycles
      bus.iaddr = 12'h041;
      tick();
      check("idata_041_c1", 32'(bus.idata), 32'h00041);
      tick();
      check("idata_041_c2", 32'(bus.idata), 32'h00041);
      bus.iaddr = 12'hFFF;
      tick();
      check("idata_fff", 32'(bus.idata), 32'h00FFF);

      // Fill L1 with a known pattern
      for (int i = 0; i < 1024; i++) begin
         layer_write(3'b011, 12'(i), l1_pat(i));
      end

      // L0 write/read, and the same address through L1
      layer_write(3'b001, 12'h123, 20'hABCDE);
      layer_read("l0_rd_123", 3'b001, 12'h123, 20'hABCDE);
      layer_read("l1_rd_123", 3'b011, 12'h123, l1_model[12'h123]);

      // L1 write with upper address bits set
      layer_write(3'b011, 12'hFBF, 20'h13579);
      layer_read("l1_rd_3bf", 3'b011, 12'h3BF, 20'h13579);
      layer_read("l1_rd_fbf_alias", 3'b011, 12'hFBF, 20'h13579);

      // Write with an unmapped select changes nothing
      layer_write(3'b001, 12'h3C0, 20'h0BEEF);
      layer_write(3'b010, 12'h3C0, 20'hFFFFF);
      layer_read("l0_after_sel010", 3'b001, 12'h3C0, l0_model[12'h3C0]);
      layer_read("l1_after_sel010", 3'b011, 12'h3C0, l1_model[12'h3C0]);

      // Unmapped read select gives zero; crd low holds the value
      layer_read("rd_sel010_zero", 3'b010, 12'h123, 20'h00000);
      layer_read("l0_rd_again", 3'b001, 12'h123, 20'hABCDE);
      held = 20'hABCDE;
      bus.caddr_rd = 12'h3C0;
      tick();
      check("crd0_hold", 32'(bus.cdata_rd), 32'(held));

      // Simultaneous write and read to one address returns the old word
      bus.cwr = 1'b1;  bus.crd = 1'b1;  bus.csel = 3'b001;
      bus.caddr_wr = 12'h123;  bus.cdata_wr = 20'h11111;  bus.caddr_rd = 12'h123;
      exp_q.push_back(l0_model[12'h123]);
      tick();
      bus.cwr = 1'b0;  bus.crd = 1'b0;
      l0_model[12'h123] = 20'h11111;
      check("rbw_old", 32'(bus.cdata_rd), 32'(exp_q.pop_front()));
      layer_read("rbw_new", 3'b001, 12'h123, 20'h11111);

      // Drop busy: DUMP begins, output pre-fetched one cycle later
      for (int i = 0; i < 1024; i++) exp_q.push_back(l1_model[i]);
      bus.busy = 1'b0;
      tick();
      check("dump_prefetch_gap", 32'(bus.out_valid), 32'h0);
      tick();
      check("dump_first_valid", 32'(bus.out_valid), 32'h1);
      check("dump_first_word", 32'(bus.out_data), 32'(l1_model[0]));

      // Dump with out_ready toggling 1,0,1,...
      idx = 0;  cyc = 0;  done_cnt = 0;  rdy = 1'b1;
      prev_stall = 1'b0;  prev_data = '0;
      while (idx < 1024 && cyc < 5000) begin
         if (prev_stall) check("stall_hold", 32'(bus.out_data), 32'(prev_data));
         bus.out_ready = rdy;
         if (bus.out_valid && rdy) begin
            check("dump_word", 32'(bus.out_data), 32'(exp_q.pop_front()));
            check("dump_last", 32'(bus.out_last), 32'(idx == 1023));
            idx++;
         end
         prev_stall = bus.out_valid && !rdy;
         prev_data  = bus.out_data;
         rdy = ~rdy;
         tick();
         cyc++;
         if (bus.done) done_cnt++;
      end
      check("dump_count", 32'(idx), 32'd1024);
      check("done_after_last", 32'(bus.done), 32'h1);
      bus.out_ready = 1'b0;
      repeat (4) begin
         tick();
         if (bus.done) done_cnt++;
      end
      check("done_pulses", 32'(done_cnt), 32'h1);
      check("idle_out_valid", 32'(bus.out_valid), 32'h0);
      check("idle_in_ready_end", 32'(bus.in_ready), 32'h0);
      check("idle_ready_end", 32'(bus.ready), 32'h0);
      check("queue_empty", 32'(exp_q.size()), 32'h0);

      // Second run: busy already high on entry to START
      bus.busy = 1'b1;
      load_image(4096, 20'h40000);
      check("r2_ready_one_cycle", 32'(bus.ready), 32'h1);
      tick();
      check("r2_ready_drop", 32'(bus.ready), 32'h0);
      bus.iaddr = 12'h041;
      tick();
      check("r2_idata_041", 32'(bus.idata), 32'h40041);
      repeat (47) tick();

      // Full dump with out_ready held high: 1025 cycles, then DONE
      for (int i = 0; i < 1024; i++) exp_q.push_back(l1_model[i]);
      bus.out_ready = 1'b1;
      bus.busy = 1'b0;
      tick();
      cyc = 0;
      while (!bus.done && cyc < 3000) begin
         if (bus.out_valid) begin
            check("r2_dump_word", 32'(bus.out_data), 32'(exp_q.pop_front()));
         end
         tick();
         cyc++;
      end
      check("r2_dump_cycles", 32'(cyc), 32'd1025);
      check("r2_queue_empty", 32'(exp_q.size()), 32'h0);
      tick();
      check("r2_done_cleared", 32'(bus.done), 32'h0);
      check("r2_idle_in_ready", 32'(bus.in_ready), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
